exec_unit_param: RTL
====================

Name: exec_unit_param

Overview:
Parametrised next-generation execution stage for the pipelined core.
- Keeps the existing 5-bit opcode map, the registered ans/data_out/DM_data outputs and the {parity, overflow, zero, carry} flag nibble.
- Generalises the datapath to WIDTH bits.
- Adds a valid/ready handshake and multi-cycle iterative multiply and divide, so the pipeline can stall on long operations.

Parameters:
- WIDTH, 8, datapath width in bits; must be at least 4.
- SHW, $clog2(WIDTH), number of low B bits used as the shift amount (derived; do not override).

Ports:
- clk  in  1  single system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  op, a, b and data_in are valid this cycle.
- in_ready  out  1  unit can accept an operation this cycle.
- op  in  5  decoded opcode.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B, or immediate.
- data_in  in  WIDTH  load data.
- out_valid  out  1  one-cycle pulse: ans and flags hold a new result.
- ans  out  WIDTH  registered result.
- data_out  out  WIDTH  registered store data.
- dm_data  out  WIDTH  registered copy of b, captured on accept.
- flags  out  4  {P, V, Z, C}, registered with ans.
- mul_hi  out  WIDTH  high word of the last product.
- div_rem  out  WIDTH  remainder of the last divide.

Behaviour:
Reset:
- Clock and reset: one clock, clk; reset is asynchronous and active-high.
- Asserting reset forces every output register to 0 immediately and the FSM to IDLE.
- in_ready is 1 the first cycle after reset deasserts.
- Reset during MUL or DIV aborts the operation; no out_valid is produced.

Handshake:
- An operation is accepted on a rising edge where in_valid and in_ready are both 1.
- in_valid while in_ready is 0 is ignored; no queuing.

Single-cycle opcodes (latency 1, out_valid high the cycle after accept):
- ADD 00000/01000, SUB 00001/01001, MOV 00010/01010 (ans=b).
- AND 00100/01100, OR 00101/01101, XOR 00110/01110, NOT 00111/01111 (ans=~b).
- PASS 10100/10101 (ans=a), LOAD 10110 (ans=data_in).
- SL 11001, SR 11010, SAR 11011: shift by b[SHW-1:0]; SAR fills with a[WIDTH-1].
- STORE 10111: data_out<=a.
- All other opcodes are HOLD: ans unchanged, flags <= 0.
- data_out changes only on STORE.

Arithmetic and flags:
- ADD and SUB are computed WIDTH+1 bits wide.
- SUB is a + ~b + 1. C = bit WIDTH of the sum, so for SUB, C=1 means no borrow.
- V = carry into the MSB XOR carry out of the MSB.
- Z = ~|ans; P = ^ans.
- Logic, MOV, LOAD and shift ops: flags = {P, 0, Z, 0}.
- PASS, STORE and HOLD: flags = 0.

FSM states: IDLE, MUL, DIV, DONE.
- IDLE -> MUL on accepting 00011; IDLE -> DIV on accepting 01011.
- MUL: unsigned shift-add, one bit per cycle.
- DIV: unsigned restoring division, one quotient bit per cycle.
- An iteration counter runs from 0 to WIDTH-1; at WIDTH-1 the FSM goes to DONE.
- DONE: results are registered, out_valid=1, then the FSM returns to IDLE.
- in_ready=1 only in IDLE.
- Total latency from accept to out_valid is WIDTH+1 cycles.

MUL results:
- ans = low word of the product; mul_hi = high word.
- C = V = (mul_hi != 0); Z and P are computed on ans.

DIV results:
- ans = quotient; div_rem = remainder; flags = {P, 0, Z, 0}.
- Divide by zero: ans = all ones, div_rem = a, V = 1; the operation still takes WIDTH+1 cycles.

mul_hi and div_rem hold their values until the next MUL or DIV.

Optional Feature:
Macro: EXEC_MULDIV_EN.
- Defined: the MUL/DIV FSM, mul_hi and div_rem are implemented exactly as above.
- Undefined:
  - 00011 and 01011 decode as HOLD with single-cycle latency.
  - in_ready is tied to 1 and the FSM is removed.
  - mul_hi and div_rem are tied to 0.

Decomposition:
- Package exec_pkg contains:
  - opcode localparams: OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_STORE, and the rest of the map;
  - flag bit indices: FLG_P=3, FLG_V=2, FLG_Z=1, FLG_C=0;
  - the FSM state enum.
- One sub-module, exec_seq_muldiv, holds the iterative MUL/DIV datapath, counter and FSM.
- The parent contains the single-cycle ALU, the flag logic and the output registers.

Test Plan (WIDTH=8):
1. ADD a=0x7F b=0x01 -> next cycle ans=0x80, flags=4'b1100, out_valid pulses once.
2. SUB a=0x05 b=0x05 -> ans=0x00, flags=4'b0011. Then SAR a=0x80 b=0x03 -> ans=0xF0, flags=4'b0000.
3. MUL a=0x10 b=0x20:
   - in_ready=0 for 9 cycles;
   - out_valid 9 cycles after accept;
   - ans=0x00, mul_hi=0x02, flags=4'b0111.
   - in_valid pulses with ADD during the busy window are ignored.
4. DIV a=0x64 b=0x07 -> ans=0x0E, div_rem=0x02, flags=4'b1000. DIV a=0x2A b=0x00 -> ans=0xFF, div_rem=0x2A, flags=4'b0100.
5. Start MUL, assert reset at iteration 4:
   - all outputs 0 asynchronously;
   - in_ready=1 after release;
   - no stale out_valid.
6. STORE a=0x5A, then HOLD op 10000 -> data_out=0x5A and ans unchanged; flags=0 after each.
   - Rebuild without EXEC_MULDIV_EN: op 00011 gives latency 1, ans unchanged, in_ready always 1.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared opcode map, flag bit positions and FSM states for the parametrised execution stage.
package exec_pkg;

    localparam int unsigned OPW  = 5;
    localparam int unsigned NFLG = 4;

    localparam logic [OPW-1:0] OP_ADD   = 5'b00000;
    localparam logic [OPW-1:0] OP_ADDI  = 5'b01000;
    localparam logic [OPW-1:0] OP_SUB   = 5'b00001;
    localparam logic [OPW-1:0] OP_SUBI  = 5'b01001;
    localparam logic [OPW-1:0] OP_MOV   = 5'b00010;
    localparam logic [OPW-1:0] OP_MOVI  = 5'b01010;
    localparam logic [OPW-1:0] OP_MUL   = 5'b00011;
    localparam logic [OPW-1:0] OP_DIV   = 5'b01011;
    localparam logic [OPW-1:0] OP_AND   = 5'b00100;
    localparam logic [OPW-1:0] OP_ANDI  = 5'b01100;
    localparam logic [OPW-1:0] OP_OR    = 5'b00101;
    localparam logic [OPW-1:0] OP_ORI   = 5'b01101;
    localparam logic [OPW-1:0] OP_XOR   = 5'b00110;
    localparam logic [OPW-1:0] OP_XORI  = 5'b01110;
    localparam logic [OPW-1:0] OP_NOT   = 5'b00111;
    localparam logic [OPW-1:0] OP_NOTI  = 5'b01111;
    localparam logic [OPW-1:0] OP_HOLD  = 5'b10000;
    localparam logic [OPW-1:0] OP_PASS  = 5'b10100;
    localparam logic [OPW-1:0] OP_PASSI = 5'b10101;
    localparam logic [OPW-1:0] OP_LOAD  = 5'b10110;
    localparam logic [OPW-1:0] OP_STORE = 5'b10111;
    localparam logic [OPW-1:0] OP_SL    = 5'b11001;
    localparam logic [OPW-1:0] OP_SR    = 5'b11010;
    localparam logic [OPW-1:0] OP_SAR   = 5'b11011;

    localparam int unsigned FLG_P = 3;
    localparam int unsigned FLG_V = 2;
    localparam int unsigned FLG_Z = 1;
    localparam int unsigned FLG_C = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        FK_NONE,
        FK_LOGIC,
        FK_ARITH
    } flag_kind_e;

endpackage

// File: rtl/exec_seq_muldiv.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per cycle.
// hi/lo hold {product high, product low} for MUL and {remainder, quotient} for DIV.
module exec_seq_muldiv
    import exec_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_mul_i,
    input  logic             start_div_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             idle_o,
    output logic             done_o,
    output logic             is_div_o,
    output logic             div0_o,
    output logic [WIDTH-1:0] lo_o,
    output logic [WIDTH-1:0] hi_o
);

    localparam int unsigned CNTW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e            state_q, state_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  hi_q, hi_d;
    logic [WIDTH-1:0]  lo_q, lo_d;
    logic [WIDTH-1:0]  opnd_q, opnd_d;
    logic              is_div_q, is_div_d;
    logic [WIDTH:0]    mul_sum;
    logic [WIDTH:0]    trial;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        mul_sum  = {1'b0, hi_q} + {1'b0, opnd_q};
        // Bit WIDTH set means the trial subtraction went negative (restore).
        trial    = {hi_q, lo_q[WIDTH-1]} - {1'b0, opnd_q};

        unique case (state_q)
            ST_IDLE: begin
                if (start_mul_i) begin
                    state_d  = ST_MUL;
                    cnt_d    = '0;
                    hi_d     = '0;
                    lo_d     = b_i;
                    opnd_d   = a_i;
                    is_div_d = 1'b0;
                end else if (start_div_i) begin
                    state_d  = ST_DIV;
                    cnt_d    = '0;
                    hi_d     = '0;
                    lo_d     = a_i;
                    opnd_d   = b_i;
                    is_div_d = 1'b1;
                end
            end
            ST_MUL: begin
                if (lo_q[0]) begin
                    {hi_d, lo_d} = {mul_sum, lo_q[WIDTH-1:1]};
                end else begin
                    {hi_d, lo_d} = {1'b0, hi_q, lo_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + CNTW'(1);
                if (cnt_q == CNTW'(WIDTH - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DIV: begin
                if (!trial[WIDTH]) begin
                    hi_d = trial[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], 1'b1};
                end else begin
                    hi_d = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
                    lo_d = {lo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + CNTW'(1);
                if (cnt_q == CNTW'(WIDTH - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign idle_o   = (state_q == ST_IDLE);
    assign done_o   = (state_q == ST_DONE);
    assign is_div_o = is_div_q;
    assign div0_o   = (opnd_q == '0);
    assign lo_o     = lo_q;
    assign hi_o     = hi_q;

endmodule

// File: rtl/exec_unit_param.sv
// Parametrised execution stage: single-cycle ALU, flags and output registers.
// Define EXEC_MULDIV_EN to build the iterative MUL/DIV path with its valid/ready stall.
module exec_unit_param
    import exec_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] data_in,
    output logic             out_valid,
    output logic [WIDTH-1:0] ans,
    output logic [WIDTH-1:0] data_out,
    output logic [WIDTH-1:0] dm_data,
    output logic [NFLG-1:0]  flags,
    output logic [WIDTH-1:0] mul_hi,
    output logic [WIDTH-1:0] div_rem
);

    logic             accept;
    logic             md_start;
    logic             is_sub;
    logic [WIDTH-1:0] b_x;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] low;
    logic [WIDTH-1:0] alu_res;
    logic [NFLG-1:0]  alu_flags;
    logic             alu_hold;
    logic             alu_store;
    flag_kind_e       kind;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] ans_q, ans_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic [WIDTH-1:0] dm_q, dm_d;
    logic [NFLG-1:0]  flags_q, flags_d;

    assign accept = in_valid & in_ready;

`ifdef EXEC_MULDIV_EN
    logic             md_idle;
    logic             md_done;
    logic             md_is_div;
    logic             md_div0;
    logic [WIDTH-1:0] md_lo;
    logic [WIDTH-1:0] md_hi;
    logic [WIDTH-1:0] mul_hi_q, mul_hi_d;
    logic [WIDTH-1:0] div_rem_q, div_rem_d;

    assign md_start = accept & ((op == OP_MUL) | (op == OP_DIV));

    exec_seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk         (clk),
        .reset       (reset),
        .start_mul_i (accept & (op == OP_MUL)),
        .start_div_i (accept & (op == OP_DIV)),
        .a_i         (a),
        .b_i         (b),
        .idle_o      (md_idle),
        .done_o      (md_done),
        .is_div_o    (md_is_div),
        .div0_o      (md_div0),
        .lo_o        (md_lo),
        .hi_o        (md_hi)
    );

    assign in_ready = md_idle;
    assign mul_hi   = mul_hi_q;
    assign div_rem  = div_rem_q;
`else
    assign md_start = 1'b0;
    assign in_ready = 1'b1;
    assign mul_hi   = '0;
    assign div_rem  = '0;
`endif

    // Single-cycle ALU; SUB reuses the adder as a + ~b + 1.
    always_comb begin
        is_sub    = (op == OP_SUB) || (op == OP_SUBI);
        b_x       = is_sub ? ~b : b;
        sum       = {1'b0, a} + {1'b0, b_x} + (WIDTH+1)'(is_sub);
        low       = {1'b0, a[WIDTH-2:0]} + {1'b0, b_x[WIDTH-2:0]} + WIDTH'(is_sub);
        alu_res   = '0;
        kind      = FK_NONE;
        alu_hold  = 1'b0;
        alu_store = 1'b0;

        unique case (op)
            OP_ADD, OP_ADDI, OP_SUB, OP_SUBI: begin
                alu_res = sum[WIDTH-1:0];
                kind    = FK_ARITH;
            end
            OP_MOV, OP_MOVI: begin alu_res = b;         kind = FK_LOGIC; end
            OP_AND, OP_ANDI: begin alu_res = a & b;     kind = FK_LOGIC; end
            OP_OR,  OP_ORI:  begin alu_res = a | b;     kind = FK_LOGIC; end
            OP_XOR, OP_XORI: begin alu_res = a ^ b;     kind = FK_LOGIC; end
            OP_NOT, OP_NOTI: begin alu_res = ~b;        kind = FK_LOGIC; end
            OP_LOAD:         begin alu_res = data_in;   kind = FK_LOGIC; end
            OP_SL:  begin alu_res = a << b[SHW-1:0];    kind = FK_LOGIC; end
            OP_SR:  begin alu_res = a >> b[SHW-1:0];    kind = FK_LOGIC; end
            OP_SAR: begin
                alu_res = WIDTH'($signed(a) >>> b[SHW-1:0]);
                kind    = FK_LOGIC;
            end
            OP_PASS, OP_PASSI: alu_res = a;
            OP_STORE: begin
                alu_hold  = 1'b1;
                alu_store = 1'b1;
            end
            default: alu_hold = 1'b1;
        endcase

        alu_flags = '0;
        if (kind != FK_NONE) begin
            alu_flags[FLG_P] = ^alu_res;
            alu_flags[FLG_Z] = ~|alu_res;
        end
        if (kind == FK_ARITH) begin
            alu_flags[FLG_V] = low[WIDTH-1] ^ sum[WIDTH];
            alu_flags[FLG_C] = sum[WIDTH];
        end
    end

    // Output register next-state: single-cycle results on accept, MUL/DIV results on done.
    always_comb begin
        out_valid_d = 1'b0;
        ans_d       = ans_q;
        flags_d     = flags_q;
        data_out_d  = data_out_q;
        dm_d        = dm_q;
`ifdef EXEC_MULDIV_EN
        mul_hi_d    = mul_hi_q;
        div_rem_d   = div_rem_q;
`endif
        if (accept) begin
            dm_d = b;
            if (!md_start) begin
                out_valid_d = 1'b1;
                flags_d     = alu_flags;
                if (!alu_hold) begin
                    ans_d = alu_res;
                end
                if (alu_store) begin
                    data_out_d = a;
                end
            end
        end
`ifdef EXEC_MULDIV_EN
        if (md_done) begin
            out_valid_d    = 1'b1;
            ans_d          = md_lo;
            flags_d        = '0;
            flags_d[FLG_P] = ^md_lo;
            flags_d[FLG_Z] = ~|md_lo;
            if (md_is_div) begin
                div_rem_d      = md_hi;
                flags_d[FLG_V] = md_div0;
            end else begin
                mul_hi_d       = md_hi;
                flags_d[FLG_V] = |md_hi;
                flags_d[FLG_C] = |md_hi;
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            ans_q       <= '0;
            flags_q     <= '0;
            data_out_q  <= '0;
            dm_q        <= '0;
`ifdef EXEC_MULDIV_EN
            mul_hi_q    <= '0;
            div_rem_q   <= '0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            ans_q       <= ans_d;
            flags_q     <= flags_d;
            data_out_q  <= data_out_d;
            dm_q        <= dm_d;
`ifdef EXEC_MULDIV_EN
            mul_hi_q    <= mul_hi_d;
            div_rem_q   <= div_rem_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign ans       = ans_q;
    assign flags     = flags_q;
    assign data_out  = data_out_q;
    assign dm_data   = dm_q;

endmodule
